// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path.
//   ETH_AXIS_DATA_W : byte-wide MAC AXI-stream data width
//   SKID_DATA_W     : payload carried through the output skid {tuser, tlast, tdata}
//   arb_state_t     : frame arbiter states
package eth_pkg;

    localparam int ETH_AXIS_DATA_W = 8;
    localparam int SKID_DATA_W     = ETH_AXIS_DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-stream skid register. Both the downstream outputs and the
// upstream ready come straight from flops, which breaks every combinational
// path through the stage while still sustaining one beat per cycle.
// Handshake: a beat moves on a port when valid and ready are both 1 at the
// rising clock edge; a producer must hold valid and data until that happens,
// and ready may depend only on registered state.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_valid    upstream beat in,   s_ready out
//   m_data/m_valid    downstream beat out, m_ready in
module axis_skid_reg #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] sk_data_q, sk_data_d;
    logic              sk_valid_q, sk_valid_d;
    logic              push;

    // Upstream is offered space only while the spare entry is empty.
    assign push = s_valid && !sk_valid_q;

    always_comb begin
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        sk_data_d  = sk_data_q;
        sk_valid_d = sk_valid_q;
        if (m_ready || !m_valid_q) begin
            // Output entry frees up: refill from the spare first to keep order.
            if (sk_valid_q) begin
                m_data_d   = sk_data_q;
                m_valid_d  = 1'b1;
                sk_valid_d = 1'b0;
            end else begin
                m_valid_d = push;
                if (push) begin
                    m_data_d = s_data;
                end
            end
        end else if (push) begin
            // Output stalled: park the in-flight beat in the spare entry.
            sk_data_d  = s_data;
            sk_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            sk_data_q  <= '0;
            sk_valid_q <= 1'b0;
        end else begin
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            sk_data_q  <= sk_data_d;
            sk_valid_q <= sk_valid_d;
        end
    end

    assign s_ready = !sk_valid_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the 1G MAC transmit stream.
// A grant is held until the frame's tlast beat is accepted. If the granted
// requester goes quiet mid-frame for TIMEOUT cycles, the MAC sees a
// terminating bad beat (tdata 0, tlast 1, tuser 1) and the rest of the
// requester's frame is swallowed up to its own tlast.
// Ports:
//   clk, rst              MAC tx clock, synchronous active-high reset
//   port_enable[N]        arbitration mask (never cuts an active frame)
//   s_axis_*[N]           requester streams, port i data at [8i+7:8i]
//   m_axis_*              registered stream to the MAC (tuser 1 = bad frame)
//   grant_valid/index     current owner; index holds its last value when idle
//   abort_pulse           high in the cycle the abort beat is pushed
//   dbg_state             arbiter state, for observation only
module eth_tx_frame_arbiter
    import eth_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         port_enable,
    input  logic [8*N_PORTS-1:0]       s_axis_tdata,
    input  logic [N_PORTS-1:0]         s_axis_tvalid,
    output logic [N_PORTS-1:0]         s_axis_tready,
    input  logic [N_PORTS-1:0]         s_axis_tlast,
    input  logic [N_PORTS-1:0]         s_axis_tuser,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic                       grant_valid,
    output logic [$clog2(N_PORTS)-1:0] grant_index,
    output logic                       abort_pulse,
    output arb_state_t                 dbg_state
);

    localparam int GW = $clog2(N_PORTS);
    // Wide enough to hold TIMEOUT itself; at least one bit when disabled.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    // First eligible port after 'last', wrapping, so 'last' itself is tried last.
    function automatic logic [GW-1:0] rr_pick(input logic [N_PORTS-1:0] elig,
                                              input logic [GW-1:0]      last);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        logic          found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = GW'((int'(last) + k) % N_PORTS);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    arb_state_t                 state_q, state_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic [GW-1:0]              last_grant_q, last_grant_d;
    logic                       grant_valid_q, grant_valid_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       abort_fire;
    logic [N_PORTS-1:0]         eligible;
    logic                       g_valid, g_last, g_user;
    logic [7:0]                 g_data;
    logic                       skid_s_valid, skid_s_ready;
    logic [SKID_DATA_W-1:0]     skid_s_data, skid_m_data;

    assign eligible = s_axis_tvalid & port_enable;
    assign g_valid  = s_axis_tvalid[grant_q];
    assign g_last   = s_axis_tlast[grant_q];
    assign g_user   = s_axis_tuser[grant_q];
    assign g_data   = s_axis_tdata[8*grant_q +: 8];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        grant_valid_d = grant_valid_q;
        timer_d       = timer_q;
        s_axis_tready = '0;
        skid_s_valid  = 1'b0;
        skid_s_data   = {g_user, g_last, g_data};
        abort_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (|eligible) begin
                    grant_d       = rr_pick(eligible, last_grant_q);
                    grant_valid_d = 1'b1;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                s_axis_tready[grant_q] = skid_s_ready;
                skid_s_valid           = g_valid;
                if (g_valid && skid_s_ready) begin
                    timer_d = '0;
                    if (g_last) begin
                        last_grant_d  = grant_q;
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end else if (!g_valid) begin
                    // Only requester silence counts; MAC backpressure does not.
                    if (timer_q != '1) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (TIMEOUT != 0 && timer_d == TIMEOUT_CNT) begin
                        state_d = ABORT;
                    end
                end
            end
            ABORT: begin
                skid_s_valid = 1'b1;
                skid_s_data  = {1'b1, 1'b1, 8'h00};
                if (skid_s_ready) begin
                    abort_fire = 1'b1;
                    timer_d    = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // Swallow the rest of the dead frame so the requester realigns.
                s_axis_tready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    last_grant_d  = grant_q;
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(N_PORTS - 1);
            grant_valid_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            grant_valid_q <= grant_valid_d;
            timer_q       <= timer_d;
        end
    end

    axis_skid_reg #(
        .DATA_W (SKID_DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (skid_s_data),
        .s_valid (skid_s_valid),
        .s_ready (skid_s_ready),
        .m_data  (skid_m_data),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = skid_m_data;
    assign grant_valid = grant_valid_q;
    assign grant_index = grant_q;
    assign abort_pulse = abort_fire;
    assign dbg_state   = state_q;

endmodule
